// File: rtl/work_mng_types_pkg.sv
// Shared types and default widths for the fan PWM capture path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package work_mng_types_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_DUTY_W = 8;

    // Capture FSM: waiting for the first rise, inside the high phase, inside the low phase
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: quo = floor(num * 2^DUTY_W / den), assuming num < den.
// Latency: load on start, DUTY_W step cycles; done/quo_o are valid combinationally during the last step.
// Backpressure: none; busy_o is high while dividing, abort_i drops the divide at once.
module pwm_duty_div
    import work_mng_types_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  num_i,
    input  logic [CNT_W-1:0]  den_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DUTY_W-1:0] quo_o
);

    localparam int SW = $clog2(DUTY_W + 1);

    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  den_q;
    logic [DUTY_W-1:0] quo_q;
    logic [SW-1:0]     step_q;
    logic              busy_q;

    logic [CNT_W-1:0]  rem_sh;
    logic [CNT_W-1:0]  rem_nx;
    logic              ge;
    logic [DUTY_W-1:0] quo_nx;
    logic              last;

    // One restoring step; the bit shifted out of rem counts toward the compare so no extra width is needed
    always_comb begin
        rem_sh = {rem_q[CNT_W-2:0], 1'b0};
        ge     = rem_q[CNT_W-1] | (rem_sh >= den_q);
        rem_nx = ge ? (rem_sh - den_q) : rem_sh;
        quo_nx = {quo_q[DUTY_W-2:0], ge};
        last   = busy_q && (step_q == SW'(1));
    end

    // Load operands on start, then shift one quotient bit in per cycle, MSB first
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (abort_i) begin
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= num_i;
            den_q  <= den_i;
            quo_q  <= '0;
            step_q <= SW'(DUTY_W);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
            step_q <= step_q - SW'(1);
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = last;
    assign quo_o  = quo_nx;

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty of an asynchronous fan PWM input; flags a stalled waveform.
// Latency: 2-flop sync + edge detect, then results 9 cycles after the closing rise (DUTY_W=8).
// Backpressure: none; a period completing while the divider is busy is dropped and overrun pulses.
module pwm_capture
    import work_mng_types_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DUTY_W  = DEF_DUTY_W,
    parameter int TIMEOUT = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pwm_in,
    input  logic              en,
    output logic [CNT_W-1:0]  period_cnt,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              stuck,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_FULL = CNT_W'(TIMEOUT);

    logic              sync1_q, s_q, prev_q;
    cap_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q, idle_q, hi_tmp_q;
    logic [CNT_W-1:0]  per_res_q, hi_res_q;
    logic [CNT_W-1:0]  period_q, high_q;
    logic [DUTY_W-1:0] duty_q;
    logic              valid_q, stuck_q, overrun_q;

    logic              rise, fall, timeout_hit, period_done, div_free, accept, drop;
    logic [CNT_W-1:0]  cnt_inc;
    logic              div_busy, div_done;
    logic [DUTY_W-1:0] div_quo;

    // Synchronizer and previous-value register keep running regardless of en
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            s_q     <= sync1_q;
            prev_q  <= s_q;
        end
    end

    // Edge events and the accept/drop decision; a divider finishing this cycle counts as free
    always_comb begin
        rise        = s_q & ~prev_q;
        fall        = ~s_q & prev_q;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        timeout_hit = en && !rise && !fall && (idle_q == TO_LAST);
        period_done = en && (state_q == ST_LOW) && rise;
        div_free    = !div_busy || div_done;
        accept      = period_done && div_free;
        drop        = period_done && !div_free;
    end

    // Cycles since the last edge; parks at TIMEOUT so the stall fires only once per quiet stretch
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idle_q <= '0;
        end else if (!en) begin
            idle_q <= '0;
        end else if (rise || fall) begin
            idle_q <= CNT_W'(1);
        end else if (idle_q != TO_FULL) begin
            idle_q <= idle_q + CNT_W'(1);
        end
    end

    // Capture FSM, period/high counters and registered result outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_tmp_q  <= '0;
            per_res_q <= '0;
            hi_res_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            if (!en) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else if (timeout_hit) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                stuck_q  <= 1'b1;
                duty_q   <= {DUTY_W{s_q}};
                period_q <= '0;
                high_q   <= '0;
                valid_q  <= 1'b1;
            end else begin
                if (div_done) begin
                    period_q <= per_res_q;
                    high_q   <= hi_res_q;
                    duty_q   <= div_quo;
                    valid_q  <= 1'b1;
                end
                if (drop) begin
                    overrun_q <= 1'b1;
                end
                if (rise) begin
                    stuck_q <= 1'b0;
                end
                // Results travel with the divide so a later fall cannot corrupt them
                if (accept) begin
                    per_res_q <= cnt_q;
                    hi_res_q  <= hi_tmp_q;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ST_HIGH: begin
                        cnt_q <= cnt_inc;
                        if (fall) begin
                            hi_tmp_q <= cnt_q;
                            state_q  <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    pwm_duty_div #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .CLK     (CLK),
        .RST     (RST),
        .start_i (accept),
        .abort_i (!en || timeout_hit),
        .num_i   (hi_tmp_q),
        .den_i   (cnt_q),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign duty       = duty_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a scoreboard of expected valid/overrun events.
// Expected results and their arrival cycles are pushed when pwm_in is driven.
// A negedge monitor pops and compares whenever valid or overrun fires.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int DUTY_W  = 8;
    localparam int TIMEOUT = 1000;

    logic              CLK = 1'b0;
    logic              RST;
    logic              pwm_in;
    logic              en;
    logic [CNT_W-1:0]  period_cnt;
    logic [CNT_W-1:0]  high_cnt;
    logic [DUTY_W-1:0] duty;
    logic              valid;
    logic              stuck;
    logic              overrun;

    pwm_capture #(
        .CNT_W   (CNT_W),
        .DUTY_W  (DUTY_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pwm_in     (pwm_in),
        .en         (en),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .duty       (duty),
        .valid      (valid),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int t;
        int per;
        int hi;
        int dty;
        int stk;
    } exp_t;

    exp_t exp_q[$];
    int   ov_q[$];
    exp_t e;

    int n_pass  = 0;
    int n_total = 0;

    // model state
    bit armed    = 1'b0;
    int last_rise = 0;
    int last_high = 0;
    int last_acc  = -100;
    int lp_per = 0, lp_hi = 0, lp_duty = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int duty_of(input int h, input int p);
        return (h * (1 << DUTY_W)) / p;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drive a rising edge; a completed period is accepted if the divider has had 8 cycles since its last start
    task automatic rise_now();
        int p;
        pwm_in = 1'b1;
        if (armed) begin
            p = cyc - last_rise;
            if (cyc + 2 >= last_acc + 8) begin
                lp_per  = p;
                lp_hi   = last_high;
                lp_duty = duty_of(last_high, p);
                exp_q.push_back('{cyc + 11, p, last_high, lp_duty, 0});
                last_acc = cyc + 2;
            end else begin
                ov_q.push_back(cyc + 3);
            end
        end
        armed     = 1'b1;
        last_rise = cyc;
    endtask

    task automatic fall_now();
        pwm_in    = 1'b0;
        last_high = cyc - last_rise;
    endtask

    task automatic pulse(input int h, input int l);
        rise_now();
        wait_n(h);
        fall_now();
        wait_n(l);
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("valid_cycle", cyc, e.t);
                chk("period_cnt", period_cnt, e.per);
                chk("high_cnt", high_cnt, e.hi);
                chk("duty", duty, e.dty);
                chk("stuck_at_valid", stuck, e.stk);
            end
        end
        if (overrun) begin
            if (ov_q.size() == 0) begin
                chk("unexpected_overrun", 1, 0);
            end else begin
                chk("overrun_cycle", cyc, ov_q.pop_front());
            end
        end
    end

    initial begin
        RST    = 1'b1;
        en     = 1'b1;
        pwm_in = 1'b0;
        wait_n(3);
        chk("rst_period", period_cnt, 0);
        chk("rst_high", high_cnt, 0);
        chk("rst_duty", duty, 0);
        chk("rst_valid", valid, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_overrun", overrun, 0);
        RST = 1'b0;
        wait_n(5);

        // 100-cycle period, 25 high
        for (int i = 0; i < 5; i++) pulse(25, 75);

        // 200-cycle period, 199 high
        for (int i = 0; i < 3; i++) pulse(199, 1);

        // Stall with the line high: closing rise, then nothing
        rise_now();
        exp_q.push_back('{cyc + TIMEOUT + 2, 0, 0, 255, 1});
        armed = 1'b0;
        wait_n(TIMEOUT + 12);
        chk("stuck_set", stuck, 1);
        chk("stuck_duty", duty, 255);
        chk("stuck_period", period_cnt, 0);
        fall_now();
        wait_n(20);
        chk("stuck_after_fall", stuck, 1);

        // Next rise clears stuck; it also starts a 6-cycle, 3-high train
        rise_now();
        wait_n(2);
        chk("stuck_before_clear", stuck, 1);
        wait_n(1);
        chk("stuck_cleared", stuck, 0);
        fall_now();
        wait_n(3);
        for (int i = 0; i < 7; i++) pulse(3, 3);
        pulse(3, 30);

        // Reset four cycles into a divide
        rise_now();
        wait_n(6);
        RST = 1'b1;
        exp_q.delete();
        ov_q.delete();
        armed    = 1'b0;
        last_acc = -100;
        #1;
        chk("midrst_period", period_cnt, 0);
        chk("midrst_high", high_cnt, 0);
        chk("midrst_duty", duty, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_stuck", stuck, 0);
        pwm_in = 1'b0;
        wait_n(3);
        RST = 1'b0;
        wait_n(10);
        pulse(10, 40);
        rise_now();
        wait_n(10);
        fall_now();
        wait_n(20);

        // Enable dropped mid-period for 50 cycles, with activity on the line
        en    = 1'b0;
        armed = 1'b0;
        wait_n(5);
        pwm_in = 1'b1;
        wait_n(20);
        pwm_in = 1'b0;
        wait_n(25);
        chk("en_hold_period", period_cnt, lp_per);
        chk("en_hold_high", high_cnt, lp_hi);
        chk("en_hold_duty", duty, lp_duty);
        en = 1'b1;
        wait_n(10);
        pulse(30, 70);
        rise_now();
        wait_n(10);
        fall_now();
        wait_n(20);

        chk("final_period", period_cnt, 100);
        chk("final_duty", duty, 76);
        chk("pending_valid", exp_q.size(), 0);
        chk("pending_overrun", ov_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
